// File: rtl/i2s_playback_buffer_pkg.sv
// Shared audio types: stereo sample widths and the {right, left} sample layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2s_playback_buffer_pkg;

    localparam int SAMPLE_W = 64;
    localparam int CHAN_W   = 32;

    typedef struct packed {
        logic [CHAN_W-1:0] right;
        logic [CHAN_W-1:0] left;
    } stereo_t;

endpackage

// File: rtl/i2s_sample_ram.sv
// Simple dual-port DEPTH x 64 sample store, registered read address (M10K style).
// Latency: read data one cycle after raddr; a same-edge write to raddr is bypassed.
// Backpressure: none; the caller guarantees write/read address legality.
module i2s_sample_ram
    import i2s_playback_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       raddr_q;
    logic                byp_vld;
    logic [SAMPLE_W-1:0] byp_dat;

    // The block RAM returns old data on read-during-write, so a write landing on
    // the address being latched for read is forwarded from a side register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
        byp_vld <= we && (waddr == raddr);
        byp_dat <= wdata;
    end

    assign rdata = byp_vld ? byp_dat : mem[raddr_q];

endmodule

// File: rtl/i2s_playback_buffer.sv
// Show-ahead stereo sample FIFO feeding the I2S serializer, with sticky underrun/overflow.
// Latency: a write is visible on fifo_ready the next cycle; head data is valid with fifo_ready.
// Backpressure: writes at full are dropped (overflow); pops only when fifo_ready.
module i2s_playback_buffer
    import i2s_playback_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic [CHAN_W-1:0]   fifo_right_data,
    output logic [CHAN_W-1:0]   fifo_left_data,
    output logic                fifo_ready,
    input  logic                fifo_ack,
    output logic [LVL_W-1:0]    level,
    output logic                underrun,
    output logic                overflow,
    input  logic                flag_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4) || (DEPTH > 256)) begin : g_bad_depth
        $error("i2s_playback_buffer: DEPTH must be a power of two in 4..256");
    end

    logic [1:0]       rst_sync;
    logic             rst_n;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic [LVL_W-1:0] level_q;
    logic             full_q;
    logic             en_q;
    logic             primed_q;
    logic             underrun_q;
    logic             overflow_q;

    logic             flush;
    logic             pop;
    logic             wr_acc;
    logic             full_nxt;
    logic             und_set;
    logic             ovf_set;
    logic [SAMPLE_W-1:0] rd_dat;
    stereo_t          head;

    // Reset asserts immediately and releases two edges later, in step with clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_comb begin
        flush    = en_q && !enable;
        pop      = fifo_ack && fifo_ready;
        wr_acc   = wr_en && !full_q && !flush;
        ovf_set  = wr_en && full_q;
        und_set  = enable && primed_q && (level_q == '0);
        wr_nxt   = flush ? '0 : wr_ptr + PW'(wr_acc);
        rd_nxt   = flush ? '0 : rd_ptr + PW'(pop);
        // Equal slot index with differing wrap bit means every slot is in use.
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            en_q       <= 1'b0;
            primed_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            level_q    <= LVL_W'(wr_nxt - rd_nxt);
            full_q     <= full_nxt;
            en_q       <= enable;
            primed_q   <= flush ? 1'b0 : (primed_q || (enable && (level_q != '0)));
            underrun_q <= und_set || (underrun_q && !flag_clr);
            overflow_q <= ovf_set || (overflow_q && !flag_clr);
        end
    end

    // The RAM latches the post-update read pointer so the new head is on its
    // output in the same cycle the registered level reports it.
    i2s_sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_nxt[AW-1:0]),
        .rdata (rd_dat)
    );

    assign head            = rd_dat;
    assign fifo_right_data = head.right;
    assign fifo_left_data  = head.left;
    assign fifo_ready      = enable && (level_q != '0);
    assign full            = full_q;
    assign level           = level_q;
    assign underrun        = underrun_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_i2s_playback_buffer.sv
// Randomized and directed bench for i2s_playback_buffer against a queue-based reference model.
module tb_i2s_playback_buffer;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [63:0]       wr_data;
    logic              wr_en;
    logic              full;
    logic [31:0]       fifo_right_data;
    logic [31:0]       fifo_left_data;
    logic              fifo_ready;
    logic              fifo_ack;
    logic [LVL_W-1:0]  level;
    logic              underrun;
    logic              overflow;
    logic              flag_clr;

    always #5 clk = ~clk;

    i2s_playback_buffer #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .full            (full),
        .fifo_right_data (fifo_right_data),
        .fifo_left_data  (fifo_left_data),
        .fifo_ready      (fifo_ready),
        .fifo_ack        (fifo_ack),
        .level           (level),
        .underrun        (underrun),
        .overflow        (overflow),
        .flag_clr        (flag_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: contents as a queue, flags as plain booleans.
    logic [63:0] mq[$];
    bit m_primed, m_und, m_ovf, m_en_prev;

    task automatic model_reset();
        mq.delete();
        m_primed  = 0;
        m_und     = 0;
        m_ovf     = 0;
        m_en_prev = 0;
    endtask

    task automatic model_step();
        bit flush, rdy, pop, wr_ok, ovf_set, und_set;
        int sz;
        sz      = mq.size();
        flush   = m_en_prev && !enable;
        rdy     = enable && (sz != 0);
        pop     = fifo_ack && rdy;
        wr_ok   = wr_en && (sz < DEPTH) && !flush;
        ovf_set = wr_en && (sz == DEPTH);
        und_set = enable && m_primed && (sz == 0);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (wr_ok) mq.push_back(wr_data);
        end
        m_primed  = flush ? 0 : (m_primed || (enable && sz >= 1));
        m_und     = und_set || (m_und && !flag_clr);
        m_ovf     = ovf_set || (m_ovf && !flag_clr);
        m_en_prev = enable;
    endtask

    task automatic check_outputs(input string ph);
        bit exp_rdy;
        exp_rdy = enable && (mq.size() != 0);
        check_val({ph, ".level"}, level, mq.size());
        check_val({ph, ".full"}, full, mq.size() == DEPTH);
        check_val({ph, ".ready"}, fifo_ready, exp_rdy);
        check_val({ph, ".underrun"}, underrun, m_und);
        check_val({ph, ".overflow"}, overflow, m_ovf);
        if (exp_rdy) check_val({ph, ".head"}, {fifo_right_data, fifo_left_data}, mq[0]);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string ph);
        settle();
        check_outputs(ph);
        advance();
    endtask

    task automatic check_reset_state(input string ph);
        check_val({ph, ".level"}, level, 0);
        check_val({ph, ".full"}, full, 0);
        check_val({ph, ".ready"}, fifo_ready, 0);
        check_val({ph, ".underrun"}, underrun, 0);
        check_val({ph, ".overflow"}, overflow, 0);
    endtask

    initial begin
        int pw, pa;
        reset_n  = 1'b0;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        fifo_ack = 1'b0;
        flag_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        // Prefill with playback disabled, then one write too many.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = {32'(i + 1), 32'(i)};
            cycle("fill");
        end
        wr_en   = 1'b1;
        wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        settle();
        check_val("fill.level16", level, 16);
        check_val("fill.full", full, 1);
        check_val("fill.ready", fifo_ready, 0);
        check_outputs("ovf");
        advance();
        wr_en = 1'b0;
        settle();
        check_val("ovf.flag", overflow, 1);
        check_val("ovf.level", level, 16);
        check_outputs("ovf2");
        advance();

        // Drain with ack every cycle.
        enable   = 1'b1;
        fifo_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            check_val("drain.left", fifo_left_data, i);
            check_val("drain.right", fifo_right_data, i + 1);
            check_outputs("drain");
            advance();
        end
        repeat (2) cycle("dry");
        check_val("dry.underrun", underrun, 1);
        check_val("dry.ready", fifo_ready, 0);
        fifo_ack = 1'b0;

        enable = 1'b0;
        cycle("dis");
        flag_clr = 1'b1;
        cycle("clr");
        flag_clr = 1'b0;
        check_val("clr.underrun", underrun, 0);
        check_val("clr.overflow", overflow, 0);

        // Write into an empty buffer with a stray ack.
        enable   = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 64'hAAAA5555_12345678;
        fifo_ack = 1'b1;
        cycle("wr_empty");
        wr_en    = 1'b0;
        fifo_ack = 1'b0;
        settle();
        check_val("wr_empty.level", level, 1);
        check_val("wr_empty.left", fifo_left_data, 32'h12345678);
        check_val("wr_empty.right", fifo_right_data, 32'hAAAA5555);
        check_outputs("wr_empty2");
        advance();

        // Simultaneous write and pop at level 1.
        wr_en    = 1'b1;
        wr_data  = 64'h0123_4567_89AB_CDEF;
        fifo_ack = 1'b1;
        cycle("wr_pop");
        wr_en    = 1'b0;
        fifo_ack = 1'b0;
        settle();
        check_val("wr_pop.level", level, 1);
        check_val("wr_pop.head", {fifo_right_data, fifo_left_data}, 64'h0123_4567_89AB_CDEF);
        check_outputs("wr_pop2");
        advance();

        // Level 8, then disable with a write in the same cycle.
        for (int i = 0; i < 7; i++) begin
            wr_en   = 1'b1;
            wr_data = {$urandom, $urandom};
            cycle("fill8");
        end
        wr_en = 1'b0;
        settle();
        check_val("fill8.level", level, 8);
        check_outputs("fill8b");
        advance();
        enable  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 64'h5555_5555_5555_5555;
        cycle("flush");
        wr_en = 1'b0;
        check_val("flush.level", level, 0);
        check_val("flush.full", full, 0);
        enable = 1'b1;
        repeat (3) cycle("unprimed");
        check_val("unprimed.underrun", underrun, 0);

        // Overflow set wins over a same-cycle clear.
        enable = 1'b0;
        cycle("idle");
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = {$urandom, $urandom};
            cycle("refill");
        end
        flag_clr = 1'b1;
        cycle("ovf_clr");
        check_val("setwins.overflow", overflow, 1);
        wr_en = 1'b0;
        cycle("clr2");
        flag_clr = 1'b0;
        check_val("clr2.overflow", overflow, 0);

        // Reset mid-ack at level 5.
        enable   = 1'b1;
        fifo_ack = 1'b1;
        repeat (DEPTH - 5) cycle("to5");
        settle();
        check_val("to5.level", level, 5);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        enable   = 1'b0;
        fifo_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("midrst_hold");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        // Random traffic against the model.
        enable = 1'b1;
        pw = 50;
        pa = 50;
        for (int c = 0; c < 1000; c++) begin
            if (c % 100 == 0) begin
                pw = $urandom_range(10, 90);
                pa = $urandom_range(10, 90);
            end
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            wr_en    = ($urandom_range(0, 99) < pw);
            wr_data  = {$urandom, $urandom};
            fifo_ack = ($urandom_range(0, 99) < pa);
            flag_clr = ($urandom_range(0, 39) == 0);
            cycle("rnd");
        end
        wr_en    = 1'b0;
        fifo_ack = 1'b0;
        flag_clr = 1'b0;
        cycle("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
